fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 Parameter RESET_PC, default 30'h0, first word address fetched after reset.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 IREQ  output  1  instruction memory request.
REQ-006 IADDR  output  30  word address of the request.
REQ-007 INSTR  input  32  instruction data; valid exactly one cycle after the cycle IREQ=1.
REQ-008 REDIR_VALID  input  1  pipeline redirect (taken branch or jump).
REQ-009 REDIR_PC  input  30  redirect target word address.
REQ-010 HALT  input  1  stop issuing new fetches.
REQ-011 FQ_VALID  output  1  head entry valid toward decode.
REQ-012 FQ_READY  input  1  decode accepts head entry.
REQ-013 FQ_INSTR  output  32  head instruction.
REQ-014 FQ_PC  output  30  word address of head instruction.

Function
REQ-015 Queue SHALL be a circular FIFO with DEPTH entries of {PC[29:0], INSTR[31:0]}, read/write pointers wrapping modulo DEPTH.
REQ-016 Occupancy count and a 1-bit in-flight flag SHALL be registered; IREQ=1 only when state is RUN, HALT=0, and count+inflight < DEPTH.
REQ-017 IADDR SHALL equal the fetch PC register; fetch PC increments by 1 (word) on each issued IREQ, wrapping at 2^30-1 to 0.
REQ-018 Response captured in cycle n+1 for a request in cycle n SHALL be written to the tail with PC = IADDR of cycle n.
REQ-019 Pop occurs when FQ_VALID=1 and FQ_READY=1; push and pop in the same cycle SHALL leave count unchanged and both pointers advance.
REQ-020 FQ_VALID=0 when empty; FQ_INSTR/FQ_PC SHALL hold the head entry whenever FQ_VALID=1.
REQ-021 Full (count=DEPTH): no IREQ issued; an in-flight response is never lost since issue rule reserves its slot.
REQ-022 FSM states: RESET (RST high), RUN (fetching), HOLD (HALT=1, no new IREQ, in-flight response still captured, pops allowed); RESET->RUN on RST low, RUN<->HOLD follows HALT.
REQ-023 REDIR_VALID=1 SHALL, in that cycle: force FQ_VALID=0 (handshake discarded), clear count and pointers, discard any in-flight response arriving next cycle, load fetch PC with REDIR_PC.
REQ-024 In a redirect cycle with state RUN, IREQ SHALL be 1 with IADDR=REDIR_PC; fetch PC becomes REDIR_PC+1.
REQ-025 Redirect during HOLD SHALL flush and load fetch PC, without IREQ.
REQ-026 Redirect SHALL take priority over push, pop and HALT in the same cycle.
REQ-027 Default latency IREQ to FQ_VALID: 2 cycles (request n, capture n+1, visible n+2).

Reset
REQ-028 While RST=1: IREQ=0, FQ_VALID=0, count=0, pointers=0, inflight=0, fetch PC=RESET_PC, state RESET.
REQ-029 First IREQ SHALL occur in the first cycle with RST=0, IADDR=RESET_PC.
REQ-030 RST asserted mid-operation SHALL discard queue contents and any in-flight response.

Configuration
REQ-031 Macro FQ_BYPASS_EN: when defined, a response arriving while the queue is empty SHALL appear on FQ_VALID/FQ_INSTR/FQ_PC in the same cycle (latency 1); if popped that cycle it is not written to the queue.
REQ-032 Without FQ_BYPASS_EN, no combinational path from INSTR to FQ_* exists; latency per REQ-027.

Verification
REQ-033 Reset release, FQ_READY=1 constant -> IADDR 0,1,2,3... one per cycle; FQ_PC 0 at cycle 2, then +1 each cycle, FQ_INSTR matching memory.
REQ-034 FQ_READY=0, DEPTH=4 -> exactly 4 IREQ pulses (IADDR 0..3), count=4, IREQ=0 thereafter; raise FQ_READY -> FQ_PC 0,1,2,3 in order with no gaps.
REQ-035 REDIR_VALID with REDIR_PC=30'h100 while response for 0x5 in flight -> IADDR=0x100 that cycle, 0x5 never appears on FQ_PC, next FQ_PC=0x100.
REQ-036 Fetch PC at 30'h3FFFFFFF -> next IADDR=0, FQ_PC sequence 0x3FFFFFFF then 0.
REQ-037 HALT=1 with request in flight -> no further IREQ, in-flight instruction still delivered; HALT=0 resumes at next sequential address.
REQ-038 FQ_BYPASS_EN defined, empty queue -> FQ_VALID=1 one cycle after IREQ with FQ_PC=IADDR of prior cycle; undefined -> two cycles.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a DEPTH-entry circular queue toward decode.
// Optional build macro FQ_BYPASS_EN: a response arriving into an empty queue is presented in the same cycle.
// Rev 1.0
`default_nettype none

module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [29:0] RESET_PC = 30'h0
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ireq,
   output logic [29:0] iaddr,
   input  logic [31:0] instr,
   input  logic        redir_valid,
   input  logic [29:0] redir_pc,
   input  logic        halt,
   output logic        fq_valid,
   input  logic        fq_ready,
   output logic [31:0] fq_instr,
   output logic [29:0] fq_pc
);

   localparam int              PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              CW         = PW + 1;
   localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_RUN   = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state;
   logic [29:0]   r_fetch_pc;
   logic [29:0]   r_inflight_pc;
   logic          r_inflight;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [61:0]   r_mem [DEPTH];

   logic          w_room;
   logic          w_empty;
   logic          w_bypass;
   logic          w_push;
   logic          w_pop;
   logic [61:0]   w_head;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_RESET;
      else     r_state <= w_state;
   end

   // The state entered this cycle governs issue, so HALT and reset release act without a bubble.
   always_comb begin
      w_state = r_state;
      ireq    = 1'b0;
      iaddr   = r_fetch_pc;
      w_room  = (r_count + {{(CW-1){1'b0}}, r_inflight}) < FULL_COUNT;
      if (rst) begin
         w_state = ST_RESET;
      end else begin
         case (r_state)
            ST_RESET: w_state = halt ? ST_HOLD : ST_RUN;
            ST_RUN:   w_state = halt ? ST_HOLD : ST_RUN;
            ST_HOLD:  w_state = halt ? ST_HOLD : ST_RUN;
            default:  w_state = ST_RESET;
         endcase
      end
      if (w_state == ST_RUN) ireq = redir_valid | w_room;
      if (redir_valid) iaddr = redir_pc;
   end

   assign w_empty = (r_count == '0);
   assign w_head  = r_mem[r_rd_ptr];

`ifdef FQ_BYPASS_EN
   assign w_bypass = w_empty && r_inflight && !rst && !redir_valid;
   assign fq_instr = w_empty ? instr : w_head[31:0];
   assign fq_pc    = w_empty ? r_inflight_pc : w_head[61:32];
`else
   assign w_bypass = 1'b0;
   assign fq_instr = w_head[31:0];
   assign fq_pc    = w_head[61:32];
`endif

   assign fq_valid = !rst && !redir_valid && (!w_empty || w_bypass);
   assign w_pop    = fq_valid && fq_ready && !w_empty;
   // A bypassed response that is consumed immediately never occupies a slot.
   assign w_push   = r_inflight && !rst && !redir_valid && !(w_bypass && fq_ready);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {r_inflight_pc, instr};
   end

   always_ff @(posedge clk) begin
      r_inflight_pc <= iaddr;
      if (rst) begin
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_inflight <= 1'b0;
         r_fetch_pc <= RESET_PC;
      end else if (redir_valid) begin
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_inflight <= ireq;
         r_fetch_pc <= ireq ? redir_pc + 30'd1 : redir_pc;
      end else begin
         r_inflight <= ireq;
         if (ireq)   r_fetch_pc <= r_fetch_pc + 30'd1;
         if (w_push) r_wr_ptr   <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr   <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a PC scoreboard checked by an independent pop monitor.
`default_nettype none

module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        ireq;
   logic [29:0] iaddr;
   logic [31:0] instr = 32'hDEADBEEF;
   logic        redir_valid;
   logic [29:0] redir_pc;
   logic        halt;
   logic        fq_valid;
   logic        fq_ready;
   logic [31:0] fq_instr;
   logic [29:0] fq_pc;

   int          total = 0;
   int          bad   = 0;
   logic [29:0] sb [$];
   logic [29:0] mexp;

`ifdef FQ_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   always #5 clk = ~clk;

   fetch_queue #(.DEPTH(4), .RESET_PC(30'h0)) dut (
      .clk(clk), .rst(rst), .ireq(ireq), .iaddr(iaddr), .instr(instr),
      .redir_valid(redir_valid), .redir_pc(redir_pc), .halt(halt),
      .fq_valid(fq_valid), .fq_ready(fq_ready), .fq_instr(fq_instr), .fq_pc(fq_pc)
   );

   function automatic logic [31:0] memf(input logic [29:0] a);
      return {a, 2'b00} ^ 32'hA5A50F0F;
   endfunction

   // Instruction memory: data one cycle after the request.
   always @(posedge clk) instr <= ireq ? memf(iaddr) : 32'hDEADBEEF;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 30 && sb.size() != 0; i++) cyc();
      chk(name, 32'(sb.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (!rst && fq_valid === 1'b1 && fq_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pop: got pc %0h expected none", fq_pc);
         end else begin
            mexp = sb.pop_front();
            chk("sb_pc", {2'b00, fq_pc}, {2'b00, mexp});
            chk("sb_instr", fq_instr, memf(mexp));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; fq_ready = 1'b0; halt = 1'b0; redir_valid = 1'b0; redir_pc = '0;
      repeat (3) cyc();
      @(negedge clk);
      chk("rst_ireq", 32'(ireq), 32'd0);
      chk("rst_fq_valid", 32'(fq_valid), 32'd0);

      // streaming fetch from reset release
      cyc(); rst = 1'b0; fq_ready = 1'b1;
      for (int k = 0; k < 8; k++) sb.push_back(30'(k));
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("run_ireq", 32'(ireq), 32'd1);
         chk("run_iaddr", {2'b00, iaddr}, 32'(k));
         chk("run_fq_valid", 32'(fq_valid), 32'(k >= LAT));
         cyc();
      end
      halt = 1'b1;
      drain("run_drain");

      // fill to capacity with decode stalled
      rst = 1'b1; halt = 1'b0; fq_ready = 1'b0;
      cyc(); cyc(); rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("fill_ireq", 32'(ireq), 32'(k < 4));
         if (k < 4) chk("fill_iaddr", {2'b00, iaddr}, 32'(k));
         cyc();
      end
      for (int j = 0; j < 4; j++) sb.push_back(30'(j));
      fq_ready = 1'b1; halt = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         chk("full_drain_valid", 32'(fq_valid), 32'd1);
         chk("full_drain_pc", {2'b00, fq_pc}, 32'(j));
         cyc();
      end
      @(negedge clk);
      chk("full_drain_empty", 32'(fq_valid), 32'd0);
      drain("full_drain_sb");

      // redirect while the response for 0x5 is in flight
      rst = 1'b1; halt = 1'b0; fq_ready = 1'b1;
      cyc(); cyc(); rst = 1'b0;
      for (int k = 0; k < 4 + (2 - LAT); k++) sb.push_back(30'(k));
      sb.push_back(30'h100); sb.push_back(30'h101); sb.push_back(30'h102);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("pre_redir_iaddr", {2'b00, iaddr}, 32'(k));
         cyc();
      end
      redir_valid = 1'b1; redir_pc = 30'h100;
      @(negedge clk);
      chk("redir_ireq", 32'(ireq), 32'd1);
      chk("redir_iaddr", {2'b00, iaddr}, 32'h100);
      chk("redir_fq_valid", 32'(fq_valid), 32'd0);
      cyc(); redir_valid = 1'b0;
      @(negedge clk);
      chk("post_redir_iaddr1", {2'b00, iaddr}, 32'h101);
      cyc();
      @(negedge clk);
      chk("post_redir_iaddr2", {2'b00, iaddr}, 32'h102);
      cyc(); halt = 1'b1;
      drain("redir_drain");

      // redirect while held: flush and load, no request
      redir_valid = 1'b1; redir_pc = 30'h200;
      @(negedge clk);
      chk("hold_redir_ireq", 32'(ireq), 32'd0);
      cyc(); redir_valid = 1'b0; halt = 1'b0;
      sb.push_back(30'h200);
      @(negedge clk);
      chk("hold_resume_ireq", 32'(ireq), 32'd1);
      chk("hold_resume_iaddr", {2'b00, iaddr}, 32'h200);
      cyc(); halt = 1'b1;
      drain("hold_redir_drain");

      // fetch PC wraps at the top of the address space
      halt = 1'b0; redir_valid = 1'b1; redir_pc = 30'h3FFFFFFF;
      sb.push_back(30'h3FFFFFFF); sb.push_back(30'h0);
      @(negedge clk);
      chk("wrap_iaddr_top", {2'b00, iaddr}, 32'h3FFFFFFF);
      cyc(); redir_valid = 1'b0;
      @(negedge clk);
      chk("wrap_iaddr_zero", {2'b00, iaddr}, 32'h0);
      cyc(); halt = 1'b1;
      drain("wrap_drain");

      // halt with a request in flight, then resume sequentially
      halt = 1'b0;
      sb.push_back(30'h1); sb.push_back(30'h2);
      @(negedge clk);
      chk("halt_pre_iaddr", {2'b00, iaddr}, 32'h1);
      cyc(); halt = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("halt_ireq", 32'(ireq), 32'd0);
         cyc();
      end
      chk("halt_delivered", 32'(sb.size()), 32'd1);
      halt = 1'b0;
      @(negedge clk);
      chk("halt_resume_iaddr", {2'b00, iaddr}, 32'h2);
      cyc(); halt = 1'b1;
      drain("halt_drain");

      // reset in the middle of a fill discards everything
      halt = 1'b0; fq_ready = 1'b0;
      repeat (6) cyc();
      rst = 1'b1;
      cyc();
      @(negedge clk);
      chk("midrst_fq_valid", 32'(fq_valid), 32'd0);
      chk("midrst_ireq", 32'(ireq), 32'd0);
      cyc(); rst = 1'b0; fq_ready = 1'b1;
      sb.push_back(30'h0);
      @(negedge clk);
      chk("after_rst_fq_valid", 32'(fq_valid), 32'd0);
      chk("after_rst_iaddr", {2'b00, iaddr}, 32'h0);
      cyc(); halt = 1'b1;
      drain("after_rst_drain");

      repeat (3) cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
